// File: rtl/dsp_mac_sequencer_pkg.sv
// Shared constants and types for the DSP48A1 multiply-accumulate sequencer.
// The package defines the opmode words, the FSM state set and the tag-to-opmode mapping.
package dsp_ctrl_pkg;

    // Opmode words: X mux in [1:0], Z mux in [3:2]. Pre-adder, carry and subtract are never used.
    localparam logic [7:0] OP_FIRST = 8'h01;  // X=M, Z=0
    localparam logic [7:0] OP_ACC   = 8'h09;  // X=M, Z=P
    localparam logic [7:0] OP_HOLD  = 8'h08;  // X=0, Z=P

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        LOAD  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic logic [7:0] tag_opmode(input logic v, input logic f);
        if (!v) begin
            return OP_HOLD;
        end
        return f ? OP_FIRST : OP_ACC;
    endfunction

endpackage

// File: rtl/dsp_mac_sequencer_if.sv
// Job, operand-stream and result handshake bundle between a producer and the MAC sequencer.
interface dsp_mac_sequencer_if #(
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             s_valid;
    logic             s_ready;
    logic [17:0]      s_a;
    logic [17:0]      s_b;
    logic             res_valid;
    logic             res_ready;
    logic [47:0]      res_data;

    modport master (
        output start, len, s_valid, s_a, s_b, res_ready,
        input  busy, s_ready, res_valid, res_data
    );

    modport slave (
        input  start, len, s_valid, s_a, s_b, res_ready,
        output busy, s_ready, res_valid, res_data
    );
endinterface

// File: rtl/dsp_mac_sequencer_tag_pipe.sv
// Valid/first tag shift register that tracks each operand pair through the slice pipeline.
// Stage 0 lines up with operands on dsp_a/dsp_b; the last stage lines up with the P capture.
module dsp_tag_pipe #(
    parameter int DEPTH = 3,
    parameter int TAP   = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic in_v,
    input  logic in_f,
    output logic v_head,
    output logic v_tail,
    output logic tap_v,
    output logic tap_f,
    output logic pending
);
    logic v_reg [DEPTH];
    logic f_reg [TAP+1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            v_reg[0] <= 1'b0;
            f_reg[0] <= 1'b0;
        end else begin
            v_reg[0] <= in_v;
            f_reg[0] <= in_f;
        end
    end

    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_v_stage
        always_ff @(posedge CLK) begin
            if (RST) begin
                v_reg[gi] <= 1'b0;
            end else begin
                v_reg[gi] <= v_reg[gi-1];
            end
        end
    end

    // The first flag only matters up to the opmode tap.
    for (genvar gi = 1; gi <= TAP; gi++) begin : g_f_stage
        always_ff @(posedge CLK) begin
            if (RST) begin
                f_reg[gi] <= 1'b0;
            end else begin
                f_reg[gi] <= f_reg[gi-1];
            end
        end
    end

    // A tag in the last stage is consumed at the coming edge, so it no longer counts as pending.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            pending = pending | v_reg[i];
        end
    end

    assign v_head = v_reg[0];
    assign v_tail = v_reg[DEPTH-1];
    assign tap_v  = v_reg[TAP];
    assign tap_f  = f_reg[TAP];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Drives one DSP48A1 slice as a multiply-accumulate engine: streams N operand pairs in,
// steers opmode/CEP from a tag pipe, and presents the 48-bit sum with valid/ready.
module dsp_mac_sequencer
    import dsp_ctrl_pkg::*;
#(
    parameter int LEN_W     = 8,
    parameter int PIPE_LAT  = 3,
    parameter int OPMODEREG = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    dsp_mac_sequencer_if.slave   bus,
    output logic [17:0]          dsp_a,
    output logic [17:0]          dsp_b,
    output logic [7:0]           dsp_opmode,
    output logic                 dsp_cea,
    output logic                 dsp_cem,
    output logic                 dsp_cep,
    output logic                 dsp_rstp,
    input  logic [47:0]          dsp_p
);
    localparam int OPM_TAP = PIPE_LAT - 1 - OPMODEREG;

    state_t           state_reg;
    logic [LEN_W-1:0] cnt_reg;
    logic             first_reg;
    logic [17:0]      a_reg;
    logic [17:0]      b_reg;
    logic             rstp_reg;
    logic             accept;
    logic             v_head, v_tail, tap_v, tap_f, pending;

    assign accept = (state_reg == LOAD) && bus.s_valid;

    dsp_tag_pipe #(
        .DEPTH (PIPE_LAT),
        .TAP   (OPM_TAP)
    ) u_tag_pipe (
        .CLK     (CLK),
        .RST     (RST),
        .in_v    (accept),
        .in_f    (first_reg),
        .v_head  (v_head),
        .v_tail  (v_tail),
        .tap_v   (tap_v),
        .tap_f   (tap_f),
        .pending (pending)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            first_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            rstp_reg  <= 1'b1;
        end else begin
            rstp_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.len != '0) begin
                            state_reg <= LOAD;
                            cnt_reg   <= bus.len;
                            first_reg <= 1'b1;
                        end else begin
                            // Empty job: clear P so the DONE state reports zero.
                            state_reg <= CLR;
                            rstp_reg  <= 1'b1;
                        end
                    end
                end
                CLR: state_reg <= DONE;
                LOAD: begin
                    if (bus.s_valid) begin
                        a_reg     <= bus.s_a;
                        b_reg     <= bus.s_b;
                        first_reg <= 1'b0;
                        cnt_reg   <= cnt_reg - 1'b1;
                        if (cnt_reg == LEN_W'(1)) begin
                            state_reg <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!pending) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy      = (state_reg != IDLE);
    assign bus.s_ready   = (state_reg == LOAD);
    assign bus.res_valid = (state_reg == DONE);
    assign bus.res_data  = dsp_p;

    assign dsp_a      = a_reg;
    assign dsp_b      = b_reg;
    assign dsp_cea    = v_head;
    assign dsp_cem    = (state_reg != IDLE);
    assign dsp_cep    = v_tail;
    assign dsp_rstp   = rstp_reg;
    assign dsp_opmode = tag_opmode(tap_v, tap_f);

endmodule
